// File: rtl/ysyx_22041207_axi_sram_slave_pkg.sv
// Shared AXI constants and FSM encodings for the npc AXI SRAM responder.
// axi_rw imports the same package so both ends agree on response and burst codes.
package ysyx_22041207_axi_sram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  // Only INCR bursts of at most 8 bytes per beat are served from the SRAM.
  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return (burst == AXI_BURST_INCR) && (size <= 3'd3);
  endfunction

endpackage

// File: rtl/ysyx_22041207_sram_1r1w.sv
// 64-bit wide SRAM with one synchronous read port and one byte-masked write port.
// A read and a write to the same word in one cycle returns the old contents.
module ysyx_22041207_sram_1r1w #(
  parameter int unsigned DEPTH = 65536,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [63:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_strb_i,
  input  logic [63:0]      wr_data_i
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data_q;
  logic [63:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strb_i[i]) mem[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // The read register holds its value between fetches so a stalled beat stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem[rd_idx_i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ysyx_22041207_axi_sram_slave.sv
// AXI4 responder serving the core's axi_rw master from on-chip SRAM.
// Independent read and write FSMs, one outstanding INCR burst per channel.
module ysyx_22041207_axi_sram_slave
  import ysyx_22041207_axi_sram_slave_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 64'h8000_0000,
  parameter int unsigned        DEPTH     = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_aw_valid_i,
  output logic              axi_aw_ready_o,
  input  logic [ADDR_W-1:0] axi_aw_addr_i,
  input  logic [3:0]        axi_aw_id_i,
  input  logic [7:0]        axi_aw_len_i,
  input  logic [2:0]        axi_aw_size_i,
  input  logic [1:0]        axi_aw_burst_i,
  input  logic              axi_w_valid_i,
  output logic              axi_w_ready_o,
  input  logic [63:0]       axi_w_data_i,
  input  logic [7:0]        axi_w_strb_i,
  input  logic              axi_w_last_i,
  output logic              axi_b_valid_o,
  input  logic              axi_b_ready_i,
  output logic [1:0]        axi_b_resp_o,
  output logic [3:0]        axi_b_id_o,
  input  logic              axi_ar_valid_i,
  output logic              axi_ar_ready_o,
  input  logic [ADDR_W-1:0] axi_ar_addr_i,
  input  logic [3:0]        axi_ar_id_i,
  input  logic [7:0]        axi_ar_len_i,
  input  logic [2:0]        axi_ar_size_i,
  input  logic [1:0]        axi_ar_burst_i,
  output logic              axi_r_valid_o,
  input  logic              axi_r_ready_i,
  output logic [63:0]       axi_r_data_o,
  output logic [1:0]        axi_r_resp_o,
  output logic [3:0]        axi_r_id_o,
  output logic              axi_r_last_o
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = BASE_ADDR + ADDR_W'(8 * DEPTH);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a < BASE_ADDR) || (a >= LIMIT);
  endfunction

  function automatic logic [ADDR_W-1:0] beat_incr(input logic [2:0] size);
    return ADDR_W'(1) << size;
  endfunction

  rstate_e           rstate_q, rstate_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_addr_nxt;
  logic [3:0]        r_id_q, r_id_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]        r_size_q, r_size_d;
  logic              r_bad_q, r_bad_d, r_oor_q, r_oor_d;
  logic              r_last;

  wstate_e           wstate_q, wstate_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_addr_nxt;
  logic [3:0]        w_id_q, w_id_d;
  logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]        w_size_q, w_size_d;
  logic              w_bad_q, w_bad_d, w_err_q, w_err_d;
  logic              w_last_beat, w_oor;

  logic              rd_en, wr_en;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [63:0]       rd_data;

  assign r_last = (rstate_q == R_DATA) && (r_beat_q == r_len_q);

  // Read FSM: each accepted request or non-final beat prefetches the next word.
  always_comb begin
    rstate_d   = rstate_q;
    r_addr_d   = r_addr_q;
    r_id_d     = r_id_q;
    r_len_d    = r_len_q;
    r_size_d   = r_size_q;
    r_beat_d   = r_beat_q;
    r_bad_d    = r_bad_q;
    r_oor_d    = r_oor_q;
    r_addr_nxt = r_addr_q + beat_incr(r_size_q);
    rd_en      = 1'b0;
    rd_idx     = word_idx(r_addr_q);
    case (rstate_q)
      R_IDLE: begin
        if (axi_ar_valid_i) begin
          rstate_d = R_DATA;
          r_addr_d = axi_ar_addr_i;
          r_id_d   = axi_ar_id_i;
          r_len_d  = axi_ar_len_i;
          r_size_d = axi_ar_size_i;
          r_beat_d = 8'd0;
          r_bad_d  = !burst_ok(axi_ar_burst_i, axi_ar_size_i);
          r_oor_d  = out_of_range(axi_ar_addr_i);
          rd_en    = 1'b1;
          rd_idx   = word_idx(axi_ar_addr_i);
        end
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          if (r_last) begin
            rstate_d = R_IDLE;
          end else begin
            r_addr_d = r_addr_nxt;
            r_beat_d = r_beat_q + 8'd1;
            r_oor_d  = out_of_range(r_addr_nxt);
            rd_en    = 1'b1;
            rd_idx   = word_idx(r_addr_nxt);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q <= R_IDLE;
      r_addr_q <= '0;
      r_id_q   <= '0;
      r_len_q  <= '0;
      r_size_q <= '0;
      r_beat_q <= '0;
      r_bad_q  <= 1'b0;
      r_oor_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      r_addr_q <= r_addr_d;
      r_id_q   <= r_id_d;
      r_len_q  <= r_len_d;
      r_size_q <= r_size_d;
      r_beat_q <= r_beat_d;
      r_bad_q  <= r_bad_d;
      r_oor_q  <= r_oor_d;
    end
  end

  assign w_last_beat = (w_beat_q == w_len_q);
  assign w_oor       = out_of_range(w_addr_q);

  // Write FSM: beat count ends the burst, any w_last disagreement only poisons the response.
  always_comb begin
    wstate_d   = wstate_q;
    w_addr_d   = w_addr_q;
    w_id_d     = w_id_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_beat_d   = w_beat_q;
    w_bad_d    = w_bad_q;
    w_err_d    = w_err_q;
    w_addr_nxt = w_addr_q + beat_incr(w_size_q);
    wr_en      = 1'b0;
    wr_idx     = word_idx(w_addr_q);
    case (wstate_q)
      W_IDLE: begin
        if (axi_aw_valid_i) begin
          wstate_d = W_DATA;
          w_addr_d = axi_aw_addr_i;
          w_id_d   = axi_aw_id_i;
          w_len_d  = axi_aw_len_i;
          w_size_d = axi_aw_size_i;
          w_beat_d = 8'd0;
          w_bad_d  = !burst_ok(axi_aw_burst_i, axi_aw_size_i);
          w_err_d  = 1'b0;
        end
      end
      W_DATA: begin
        if (axi_w_valid_i) begin
          wr_en    = !w_bad_q && !w_oor;
          w_err_d  = w_err_q | w_bad_q | w_oor | (axi_w_last_i != w_last_beat);
          w_addr_d = w_addr_nxt;
          w_beat_d = w_beat_q + 8'd1;
          if (w_last_beat) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q <= W_IDLE;
      w_addr_q <= '0;
      w_id_q   <= '0;
      w_len_q  <= '0;
      w_size_q <= '0;
      w_beat_q <= '0;
      w_bad_q  <= 1'b0;
      w_err_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      w_addr_q <= w_addr_d;
      w_id_q   <= w_id_d;
      w_len_q  <= w_len_d;
      w_size_q <= w_size_d;
      w_beat_q <= w_beat_d;
      w_bad_q  <= w_bad_d;
      w_err_q  <= w_err_d;
    end
  end

  ysyx_22041207_sram_1r1w #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_sram (
    .clk      (clk),
    .rst      (rst),
    .rd_en_i  (rd_en),
    .rd_idx_i (rd_idx),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_strb_i(axi_w_strb_i),
    .wr_data_i(axi_w_data_i)
  );

  // Ready outputs are masked by reset so they read 0 while rst is held low.
  assign axi_ar_ready_o = rst && (rstate_q == R_IDLE);
  assign axi_r_valid_o  = (rstate_q == R_DATA);
  assign axi_r_data_o   = (r_bad_q || r_oor_q) ? 64'd0 : rd_data;
  assign axi_r_resp_o   = (r_bad_q || r_oor_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_r_id_o     = r_id_q;
  assign axi_r_last_o   = r_last;

  assign axi_aw_ready_o = rst && (wstate_q == W_IDLE);
  assign axi_w_ready_o  = (wstate_q == W_DATA);
  assign axi_b_valid_o  = (wstate_q == W_RESP);
  assign axi_b_resp_o   = ((wstate_q == W_RESP) && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_b_id_o     = w_id_q;

endmodule

// File: tb/tb_ysyx_22041207_axi_sram_slave.sv
// Directed, table-driven bench for the AXI SRAM responder.
// Expected words are hand-computed from the write history in this file.
module tb_ysyx_22041207_axi_sram_slave;

  logic        clk;
  logic        rst;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [63:0] aw_addr, w_data;
  logic [3:0]  aw_id, b_id;
  logic [7:0]  aw_len, w_strb;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst, b_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [63:0] ar_addr, r_data;
  logic [3:0]  ar_id, r_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst, r_resp;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_rd  [16];
  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  bresp;
    logic [63:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [9];

  ysyx_22041207_axi_sram_slave dut (
    .clk           (clk),
    .rst           (rst),
    .axi_aw_valid_i(aw_valid),
    .axi_aw_ready_o(aw_ready),
    .axi_aw_addr_i (aw_addr),
    .axi_aw_id_i   (aw_id),
    .axi_aw_len_i  (aw_len),
    .axi_aw_size_i (aw_size),
    .axi_aw_burst_i(aw_burst),
    .axi_w_valid_i (w_valid),
    .axi_w_ready_o (w_ready),
    .axi_w_data_i  (w_data),
    .axi_w_strb_i  (w_strb),
    .axi_w_last_i  (w_last),
    .axi_b_valid_o (b_valid),
    .axi_b_ready_i (b_ready),
    .axi_b_resp_o  (b_resp),
    .axi_b_id_o    (b_id),
    .axi_ar_valid_i(ar_valid),
    .axi_ar_ready_o(ar_ready),
    .axi_ar_addr_i (ar_addr),
    .axi_ar_id_i   (ar_id),
    .axi_ar_len_i  (ar_len),
    .axi_ar_size_i (ar_size),
    .axi_ar_burst_i(ar_burst),
    .axi_r_valid_o (r_valid),
    .axi_r_ready_i (r_ready),
    .axi_r_data_o  (r_data),
    .axi_r_resp_o  (r_resp),
    .axi_r_id_o    (r_id),
    .axi_r_last_o  (r_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write burst from wr_data/wr_strb; bad_beat flips w_last on that beat, early raises W before AW.
  task automatic apply_stimulus_write(input string name, input logic [63:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                                      input bit early, input int bad_beat, input logic [1:0] exp_resp);
    logic hs;
    int   n;
    if (early) begin
      w_valid = 1'b1;
      w_data  = wr_data[0];
      w_strb  = wr_strb[0];
      w_last  = (len == 8'd0) ^ (bad_beat == 0);
      check_output({name, "_w_ready_before_aw"}, 64'(w_ready), 64'd0);
      next_cycle();
    end
    aw_valid = 1'b1;
    aw_addr  = addr;
    aw_len   = len;
    aw_size  = size;
    aw_burst = burst;
    aw_id    = id;
    n = 0;
    do begin
      hs = aw_ready;
      next_cycle();
      n++;
    end while (!hs && n < 20);
    aw_valid = 1'b0;
    check_output({name, "_aw_hs"}, 64'(hs), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1;
      w_data  = wr_data[i];
      w_strb  = wr_strb[i];
      w_last  = (i == int'(len)) ^ (i == bad_beat);
      n = 0;
      do begin
        hs = w_ready;
        next_cycle();
        n++;
      end while (!hs && n < 20);
      if (!hs) check_output({name, "_w_hs"}, 64'(hs), 64'd1);
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 20) begin
      next_cycle();
      n++;
    end
    check_output({name, "_b_valid"}, 64'(b_valid), 64'd1);
    check_output({name, "_b_resp"}, 64'(b_resp), 64'(exp_resp));
    check_output({name, "_b_id"}, 64'(b_id), 64'(id));
    next_cycle();
    b_ready = 1'b0;
    check_output({name, "_b_done"}, 64'(b_valid), 64'd0);
    check_output({name, "_aw_ready_after"}, 64'(aw_ready), 64'd1);
  endtask

  // Read burst compared against exp_rd; rdy_pat bit k drives r_ready on cycle k after AR.
  task automatic check_output_read(input string name, input logic [63:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                                   input logic [1:0] exp_resp, input logic [15:0] rdy_pat, input int exp_cycles);
    logic hs;
    logic rr;
    int   n;
    int   beat;
    int   cyc;
    r_ready  = 1'b0;
    ar_valid = 1'b1;
    ar_addr  = addr;
    ar_len   = len;
    ar_size  = size;
    ar_burst = burst;
    ar_id    = id;
    n = 0;
    do begin
      hs = ar_ready;
      next_cycle();
      n++;
    end while (!hs && n < 20);
    ar_valid = 1'b0;
    check_output({name, "_ar_hs"}, 64'(hs), 64'd1);
    check_output({name, "_r_valid_lat"}, 64'(r_valid), 64'd1);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 64) begin
      rr      = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
      r_ready = rr;
      if (r_valid) begin
        check_output($sformatf("%s_data%0d", name, beat), r_data, exp_rd[beat]);
        check_output($sformatf("%s_resp%0d", name, beat), 64'(r_resp), 64'(exp_resp));
        check_output($sformatf("%s_last%0d", name, beat), 64'(r_last), 64'(beat == int'(len)));
        check_output($sformatf("%s_id%0d", name, beat), 64'(r_id), 64'(id));
        if (rr) beat++;
      end
      next_cycle();
      cyc++;
    end
    r_ready = 1'b0;
    check_output({name, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    check_output({name, "_r_done"}, 64'(r_valid), 64'd0);
    check_output({name, "_ar_ready_after"}, 64'(ar_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
    ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    r_ready = 1'b0;

    vecs[0] = '{64'h8000_0100, 64'h1111_1111_2222_2222, 8'hFF, 2'b00, 64'h1111_1111_2222_2222, 2'b00};
    vecs[1] = '{64'h8000_0100, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 2'b00, 64'h1111_1111_AAAA_AAAA, 2'b00};
    vecs[2] = '{64'h8000_0100, 64'h5500_0000_0000_0000, 8'h80, 2'b00, 64'h5511_1111_AAAA_AAAA, 2'b00};
    vecs[3] = '{64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 64'h5511_1111_AAAA_AAAA, 2'b00};
    vecs[4] = '{64'h8007_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00};
    vecs[5] = '{64'h8008_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 64'h0, 2'b10};
    vecs[6] = '{64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 64'h0, 2'b10};
    vecs[7] = '{64'h8007_FFF8, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00};
    vecs[8] = '{64'h8000_0000, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ar_ready", 64'(ar_ready), 64'd0);
    check_output("rst_aw_ready", 64'(aw_ready), 64'd0);
    check_output("rst_w_ready", 64'(w_ready), 64'd0);
    check_output("rst_r_valid", 64'(r_valid), 64'd0);
    check_output("rst_b_valid", 64'(b_valid), 64'd0);
    check_output("rst_r_last", 64'(r_last), 64'd0);
    check_output("rst_r_data", r_data, 64'd0);
    check_output("rst_resp", {60'd0, r_resp, b_resp}, 64'd0);
    check_output("rst_ids", {56'd0, r_id, b_id}, 64'd0);
    rst = 1'b1;
    #1;
    check_output("rel_ar_ready", 64'(ar_ready), 64'd1);
    check_output("rel_aw_ready", 64'(aw_ready), 64'd1);
    next_cycle();

    wr_data[0] = 64'h1122_3344_5566_7788; wr_strb[0] = 8'hFF;
    apply_stimulus_write("t1_wr", 64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd5, 1'b0, -1, 2'b00);
    exp_rd[0] = 64'h1122_3344_5566_7788;
    check_output_read("t1_rd", 64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd5, 2'b00, 16'hFFFF, 1);

    wr_data[0] = 64'h0123_4567_89AB_CDEF; wr_data[1] = 64'hFEDC_BA98_7654_3210;
    wr_data[2] = 64'hA5A5_A5A5_5A5A_5A5A; wr_data[3] = 64'h0F0F_0F0F_F0F0_F0F0;
    for (int i = 0; i < 4; i++) begin
      wr_strb[i] = 8'hFF;
      exp_rd[i]  = wr_data[i];
    end
    apply_stimulus_write("t2_wr", 64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'd9, 1'b0, -1, 2'b00);
    check_output_read("t2_rd", 64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'd3, 2'b00, 16'hFFFF, 4);

    for (int i = 0; i < 9; i++) begin
      wr_data[0] = vecs[i].wdata;
      wr_strb[0] = vecs[i].strb;
      apply_stimulus_write($sformatf("v%0d_wr", i), vecs[i].addr, 8'd0, 3'd3, 2'b01, 4'(i), 1'b0, -1, vecs[i].bresp);
      exp_rd[0] = vecs[i].rdata;
      check_output_read($sformatf("v%0d_rd", i), vecs[i].addr, 8'd0, 3'd3, 2'b01, 4'(i), vecs[i].rresp, 16'hFFFF, 1);
    end

    exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
    check_output_read("t4_rd_oor", 64'h7000_0000, 8'd1, 3'd3, 2'b01, 4'd2, 2'b10, 16'hFFFF, 2);
    wr_data[0] = 64'h9999_9999_9999_9999; wr_strb[0] = 8'hFF;
    apply_stimulus_write("t4_wr_oor", 64'h7000_0000, 8'd0, 3'd3, 2'b01, 4'd2, 1'b0, -1, 2'b10);
    exp_rd[0] = 64'h1122_3344_5566_7788;
    check_output_read("t4_alias", 64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd2, 2'b00, 16'hFFFF, 1);

    exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
    check_output_read("t5_rd_wrap", 64'h8000_0010, 8'd1, 3'd3, 2'b10, 4'd7, 2'b10, 16'hFFFF, 2);
    check_output_read("t5_rd_size4", 64'h8000_0010, 8'd0, 3'd4, 2'b01, 4'd7, 2'b10, 16'hFFFF, 1);
    wr_data[0] = 64'hBAD0_BAD0_BAD0_BAD0; wr_data[1] = 64'hBAD1_BAD1_BAD1_BAD1;
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    apply_stimulus_write("t5_wr_fixed", 64'h8000_0010, 8'd1, 3'd3, 2'b00, 4'd7, 1'b0, -1, 2'b10);
    exp_rd[0] = 64'h0123_4567_89AB_CDEF; exp_rd[1] = 64'hFEDC_BA98_7654_3210;
    check_output_read("t5_keep", 64'h8000_0010, 8'd1, 3'd3, 2'b01, 4'd7, 2'b00, 16'hFFFF, 2);

    wr_data[0] = 64'h1010_1010_1010_1010; wr_data[1] = 64'h2020_2020_2020_2020;
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    apply_stimulus_write("t6_lastbad", 64'h8000_0200, 8'd1, 3'd3, 2'b01, 4'd11, 1'b1, 0, 2'b10);
    exp_rd[0] = wr_data[0]; exp_rd[1] = wr_data[1];
    check_output_read("t6_rd", 64'h8000_0200, 8'd1, 3'd3, 2'b01, 4'd11, 2'b00, 16'hFFFF, 2);
    wr_data[0] = 64'h3030_3030_3030_3030;
    apply_stimulus_write("t6_early", 64'h8000_0208, 8'd0, 3'd3, 2'b01, 4'd12, 1'b1, -1, 2'b00);
    exp_rd[0] = 64'h1010_1010_1010_1010; exp_rd[1] = 64'h3030_3030_3030_3030;
    check_output_read("t6_rd2", 64'h8000_0200, 8'd1, 3'd3, 2'b01, 4'd12, 2'b00, 16'hFFFF, 2);

    exp_rd[0] = 64'h0123_4567_89AB_CDEF; exp_rd[1] = 64'hFEDC_BA98_7654_3210;
    exp_rd[2] = 64'hA5A5_A5A5_5A5A_5A5A; exp_rd[3] = 64'h0F0F_0F0F_F0F0_F0F0;
    check_output_read("t7_stall", 64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'd13, 2'b00, 16'hFFF9, 6);

    ar_valid = 1'b1; ar_addr = 64'h8000_0010; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 4'd4;
    aw_valid = 1'b1; aw_addr = 64'h8000_0010; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'b01; aw_id = 4'd4;
    r_ready  = 1'b0;
    next_cycle();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    check_output("t8_r_valid_pre", 64'(r_valid), 64'd1);
    check_output("t8_w_ready_pre", 64'(w_ready), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check_output("t8_r_valid_rst", 64'(r_valid), 64'd0);
    check_output("t8_w_ready_rst", 64'(w_ready), 64'd0);
    check_output("t8_b_valid_rst", 64'(b_valid), 64'd0);
    check_output("t8_r_last_rst", 64'(r_last), 64'd0);
    check_output("t8_r_data_rst", r_data, 64'd0);
    check_output("t8_ready_rst", {62'd0, ar_ready, aw_ready}, 64'd0);
    next_cycle();
    rst = 1'b1;
    #1;
    check_output("t8_ready_rel", {62'd0, ar_ready, aw_ready}, 64'd3);
    next_cycle();
    exp_rd[0] = 64'h0123_4567_89AB_CDEF;
    check_output_read("t8_after", 64'h8000_0010, 8'd0, 3'd3, 2'b01, 4'd6, 2'b00, 16'hFFFF, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
